// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared constants, types and sizing helper for the FIFO stream reader
package fifo_stream_reader_pkg;
    localparam int BUF_DEPTH = 2;
    typedef logic [1:0] buf_cnt_t;
    function automatic int pkt_cnt_width(input int pkt_len);
        return (pkt_len > 0) ? $clog2(pkt_len + 1) : 1;
    endfunction
endpackage

// File: rtl/fifo_stream_reader_if.sv
// fifo_stream_reader_if: FIFO snoop/pop side, output stream and status of the stream reader
//   slave  (reader): fifo_wr_en, fifo_rd_data, fifo_empty, m_tready in; fifo_rd_en, m_tdata, m_tvalid,
//                    m_tlast, level, ovf_err, sync_err out
//   master (environment): the mirror image
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [ADDR_WIDTH:0]   level;
    logic                  ovf_err;
    logic                  sync_err;
    modport slave (
        input  fifo_wr_en, fifo_rd_data, fifo_empty, m_tready,
        output fifo_rd_en, m_tdata, m_tvalid, m_tlast, level, ovf_err, sync_err
    );
    modport master (
        output fifo_wr_en, fifo_rd_data, fifo_empty, m_tready,
        input  fifo_rd_en, m_tdata, m_tvalid, m_tlast, level, ovf_err, sync_err
    );
endinterface

// File: rtl/fifo_stream_reader_skid2.sv
// fifo_stream_reader_skid2: 2-entry in-order output buffer presenting its oldest entry as a valid/ready stream
//   clk, resetn (sync, active-low); push/push_data in; ready in; valid/data out (oldest entry); cnt out (0..2)
module fifo_stream_reader_skid2
    import fifo_stream_reader_pkg::*;
#(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output buf_cnt_t     cnt
);
    logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
    buf_cnt_t     cnt_q, cnt_d;
    logic         pop;

    // push is never issued at cnt==2 by the reader, so entry e1 only ever receives fresh words
    always_comb begin
        pop   = (cnt_q != '0) && ready;
        cnt_d = cnt_q + buf_cnt_t'(push) - buf_cnt_t'(pop);
        e0_d  = (pop && cnt_q == 2'd2) ? e1_q
              : (push && (cnt_q == 2'd0 || (pop && cnt_q == 2'd1))) ? push_data : e0_q;
        e1_d  = (push && ((cnt_q == 2'd1 && !pop) || (cnt_q == 2'd2 && pop))) ? push_data : e1_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
            e0_q  <= '0;
            e1_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end

    assign valid = cnt_q != '0;
    assign data  = e0_q;
    assign cnt   = cnt_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a registered-read sync FIFO into a buffered valid/ready stream with TLAST and error flags
//   clk, resetn (sync, active-low, shared with the FIFO)
//   bus.slave: fifo_wr_en/fifo_rd_data/fifo_empty in, fifo_rd_en out; m_tdata/m_tvalid/m_tlast out, m_tready in;
//              level (shadow occupancy), ovf_err, sync_err (sticky) out
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int PKT_LEN    = 0
) (
    input logic                 clk,
    input logic                 resetn,
    fifo_stream_reader_if.slave bus
);
    localparam int            LW   = ADDR_WIDTH + 1;
    localparam int            PW   = pkt_cnt_width(PKT_LEN);
    localparam logic [LW-1:0] FULL = LW'(2 ** ADDR_WIDTH);

    logic [LW-1:0]     level_q, level_d;
    logic              head_stale_q, head_stale_d;
    logic              ovf_q, ovf_d, sync_q, sync_d;
    logic [PW-1:0]     pkt_q, pkt_d;
    logic              rd_en, wr_ok, tag_last;
    logic [DATA_WIDTH:0] out_word;
    buf_cnt_t          buf_cnt;

    // head_stale: a write that lands on the head slot is not visible on fifo_rd_data until one edge later
    always_comb begin
        rd_en        = (level_q != '0) && !head_stale_q && (buf_cnt < buf_cnt_t'(BUF_DEPTH));
        wr_ok        = bus.fifo_wr_en && !(level_q == FULL && !rd_en);
        level_d      = level_q + LW'(wr_ok) - LW'(rd_en);
        head_stale_d = bus.fifo_wr_en && (rd_en ? level_q == LW'(1) : level_q == '0);
        ovf_d        = ovf_q || (bus.fifo_wr_en && !wr_ok);
        sync_d       = sync_q || ((level_q == '0) != bus.fifo_empty);
        tag_last     = (PKT_LEN != 0) && (pkt_q == PW'(PKT_LEN - 1));
        pkt_d        = (!rd_en || PKT_LEN == 0) ? pkt_q : tag_last ? '0 : pkt_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            level_q      <= '0;
            head_stale_q <= 1'b0;
            ovf_q        <= 1'b0;
            sync_q       <= 1'b0;
            pkt_q        <= '0;
        end else begin
            level_q      <= level_d;
            head_stale_q <= head_stale_d;
            ovf_q        <= ovf_d;
            sync_q       <= sync_d;
            pkt_q        <= pkt_d;
        end
    end

    fifo_stream_reader_skid2 #(.W(DATA_WIDTH + 1)) u_skid (
        .clk       (clk),
        .resetn    (resetn),
        .push      (rd_en),
        .push_data ({tag_last, bus.fifo_rd_data}),
        .ready     (bus.m_tready),
        .valid     (bus.m_tvalid),
        .data      (out_word),
        .cnt       (buf_cnt)
    );

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_tdata    = out_word[DATA_WIDTH-1:0];
    assign bus.m_tlast    = out_word[DATA_WIDTH];
    assign bus.level      = level_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.sync_err   = sync_q;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed and random stimulus through a registered-read FIFO model into the reader
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic resetn;
    logic [15:0] din;
    logic [15:0] mem [16];
    int wp, rp, cnt;
    logic do_rd, do_wr;
    logic [15:0] exp_q [$];
    int n_chk = 0, n_err = 0, out_idx = 0, n_last = 0;
    bit stall = 0;
    logic [15:0] held_d;
    logic held_l;

    fifo_stream_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .PKT_LEN(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // fifo_sync model: 16 deep, read data registered from the post-edge head slot (stale after a head write)
    assign do_rd = bus.fifo_rd_en && cnt > 0;
    assign do_wr = bus.fifo_wr_en && (cnt < 16 || do_rd);
    assign bus.fifo_empty = (cnt == 0);
    always @(posedge clk) begin
        if (!resetn) begin
            wp <= 0;
            rp <= 0;
            cnt <= 0;
            bus.fifo_rd_data <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= din;
                wp <= (wp + 1) % 16;
            end
            if (do_rd) rp <= (rp + 1) % 16;
            cnt <= cnt + int'(do_wr) - int'(do_rd);
            bus.fifo_rd_data <= mem[do_rd ? (rp + 1) % 16 : rp];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] d, input bit keep);
        bus.fifo_wr_en = 1'b1;
        din = d;
        if (keep) exp_q.push_back(d);
        step();
        bus.fifo_wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        bus.m_tready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        exp_q.delete();
        out_idx = 0;
        n_last = 0;
        repeat (cycles) step();
        resetn = 1'b1;
    endtask

    // stream monitor: in-order data, packet framing, AXI hold rule, shadow level vs FIFO occupancy
    always @(negedge clk) begin
        if (!resetn) stall = 0;
        else begin
            chk("level", bus.level, cnt);
            chk("sync_err", bus.sync_err, 0);
            chk("rd_at_empty", bus.fifo_rd_en && bus.level == 0, 0);
            if (stall) begin
                chk("hold_valid", bus.m_tvalid, 1);
                chk("hold_data", bus.m_tdata, held_d);
                chk("hold_last", bus.m_tlast, held_l);
            end
            if (bus.m_tvalid && bus.m_tready) begin
                chk("word_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    chk("data", bus.m_tdata, exp_q.pop_front());
                    chk("tlast", bus.m_tlast, out_idx % 4 == 3);
                    out_idx++;
                    n_last += int'(bus.m_tlast);
                end
            end
            stall = bus.m_tvalid && !bus.m_tready;
            held_d = bus.m_tdata;
            held_l = bus.m_tlast;
        end
    end

    initial begin
        #100000;
        $error("FAIL watchdog expired");
        $fatal;
    end

    initial begin
        int n;
        bus.fifo_wr_en = 1'b0;
        bus.m_tready = 1'b0;
        din = '0;
        do_reset(3);
        resetn = 1'b0;
        step();
        chk("rst_rd_en", bus.fifo_rd_en, 0);
        chk("rst_tvalid", bus.m_tvalid, 0);
        chk("rst_tdata", bus.m_tdata, 0);
        chk("rst_tlast", bus.m_tlast, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_sync", bus.sync_err, 0);
        resetn = 1'b1;
        step();
        // write into empty FIFO: pop two cycles after the write edge, word valid after the third edge
        bus.m_tready = 1'b1;
        wr(16'hA5A5, 1);
        chk("t1_no_early_pop", bus.fifo_rd_en, 0);
        chk("t1_no_early_valid", bus.m_tvalid, 0);
        step();
        chk("t1_pop", bus.fifo_rd_en, 1);
        step();
        chk("t1_valid", bus.m_tvalid, 1);
        chk("t1_data", bus.m_tdata, 16'hA5A5);
        chk("t1_single_pop", bus.fifo_rd_en, 0);
        drain("t1_drain");
        // back-to-back burst of 16
        for (int i = 0; i < 16; i++) wr(16'(i), 1);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        chk("t2_tail_cycles_le4", n <= 4, 1);
        chk("t2_level", bus.level, 0);
        chk("t2_ovf", bus.ovf_err, 0);
        // backpressure
        bus.m_tready = 1'b0;
        for (int i = 0; i < 8; i++) wr(16'(i), 1);
        repeat (10) step();
        chk("t3_level", bus.level, 6);
        chk("t3_no_pop", bus.fifo_rd_en, 0);
        chk("t3_valid", bus.m_tvalid, 1);
        chk("t3_data", bus.m_tdata, 16'h0000);
        drain("t3_drain");
        // write landing on the head at the same edge as the last pop
        wr(16'($urandom), 1);
        step();
        chk("t4_pop_lvl1", bus.fifo_rd_en, 1);
        chk("t4_level1", bus.level, 1);
        wr(16'h1234, 1);
        chk("t4_stale_no_pop", bus.fifo_rd_en, 0);
        chk("t4_level_hold", bus.level, 1);
        step();
        chk("t4_pop_after_stale", bus.fifo_rd_en, 1);
        step();
        chk("t4_level0", bus.level, 0);
        drain("t4_drain");
        repeat (3) step();
        chk("t4_no_duplicate", bus.m_tvalid, 0);
        // random traffic and backpressure
        for (int i = 0; i < 400; i++) begin
            bus.m_tready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 1) == 1 && cnt < 12) wr(16'($urandom), 1);
            else step();
        end
        drain("rand_drain");
        // packet framing from a fresh counter, then overflow
        do_reset(2);
        for (int i = 0; i < 10; i++) wr(16'($urandom), 1);
        drain("t5_drain");
        chk("t5_words", out_idx, 10);
        chk("t5_nlast", n_last, 2);
        bus.m_tready = 1'b0;
        for (int i = 0; i < 18; i++) wr(16'($urandom), 1);
        repeat (4) step();
        chk("t5_full", bus.level, 16);
        chk("t5_no_ovf_yet", bus.ovf_err, 0);
        wr(16'hDEAD, 0);
        chk("t5_ovf", bus.ovf_err, 1);
        chk("t5_full_hold", bus.level, 16);
        drain("t5_ovf_drain");
        chk("t5_ovf_sticky", bus.ovf_err, 1);
        // reset with the buffer full and words still in the FIFO
        bus.m_tready = 1'b0;
        for (int i = 0; i < 7; i++) wr(16'($urandom), 1);
        repeat (3) step();
        chk("t6_level5", bus.level, 5);
        chk("t6_valid_pre", bus.m_tvalid, 1);
        do_reset(1);
        chk("t6_tvalid", bus.m_tvalid, 0);
        chk("t6_level", bus.level, 0);
        chk("t6_ovf", bus.ovf_err, 0);
        chk("t6_sync", bus.sync_err, 0);
        bus.m_tready = 1'b1;
        wr(16'h5A5A, 1);
        drain("t6_post_reset");
        chk("t6_words", out_idx, 1);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
